// File: rtl/npu_pipe_reg.sv
// npu_pipe_reg: parametrised valid/ready pipeline register with bubble
// collapse, synchronous flush and asynchronous active-high reset.
// Ports: clk, reset, flush, in_valid/in_data/in_ready (upstream),
//        out_valid/out_data/out_ready (downstream), occ (optional).
// Define NPU_PIPE_OCC_EN to add the registered occupancy port occ,
// which counts the valid stages after each edge.
module npu_pipe_reg #(
   parameter int               WIDTH      = 8,
   parameter int               DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef NPU_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   localparam int DW = DEPTH * WIDTH;

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0]            nv;
   logic [DEPTH-1:0][WIDTH-1:0] nd;
   logic                        acc;
   logic                        full_tail;

   // rdy[i] = ~v[i] | (v[i] & rdy[i+1]) collapses to
   // out_ready | (some stage at or after i is empty),
   // which avoids a bit-wise feedback through the rdy vector.
   always_comb begin
      full_tail = 1'b1;
      rdy       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         full_tail = full_tail & v[i];
         rdy[i]    = out_ready | ~full_tail;
      end
   end

   assign in_ready = rdy[0] & ~flush;
   assign acc      = in_valid & in_ready;

   // Each stage's source: stage 0 sees the input, stage i sees i-1.
   assign nv = DEPTH'({v, acc});
   assign nd = DW'({d, in_data});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v <= '0;
         d <= {DEPTH{RESET_DATA}};
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
               v[i] <= nv[i];
               if (nv[i]) begin
                  d[i] <= nd[i];
               end
            end
         end
      end
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

`ifdef NPU_PIPE_OCC_EN
   localparam int OW = $clog2(DEPTH + 1);

   logic emit;

   assign emit = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ <= '0;
      end else if (flush) begin
         occ <= '0;
      end else begin
         occ <= occ + OW'(acc) - OW'(emit);
      end
   end
`endif

endmodule

// File: tb/tb_npu_pipe_reg.sv
// tb_npu_pipe_reg: directed vectors plus a short randomised
// scoreboard run for npu_pipe_reg (WIDTH=8, DEPTH=3).
module tb_npu_pipe_reg;

   localparam int         W  = 8;
   localparam int         DP = 3;
   localparam logic [7:0] RD = 8'h5A;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
`ifdef NPU_PIPE_OCC_EN
   logic [1:0]   occ;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic       iv;
      logic [7:0] di;
      logic       ordy;
      logic       fl;
      logic       ir;
      logic       ov;
      logic [7:0] od;
      int         oc;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      int         t;
   } beat_t;

   vec_t  tbl[$];
   beat_t sb[$];

   npu_pipe_reg #(
      .WIDTH      (W),
      .DEPTH      (DP),
      .RESET_DATA (RD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef NPU_PIPE_OCC_EN
      ,
      .occ       (occ)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic row(input logic iv, input logic [7:0] di,
                      input logic ordy, input logic fl,
                      input logic ir, input logic ov,
                      input logic [7:0] od, input int oc);
      vec_t r;
      r.iv = iv; r.di = di; r.ordy = ordy; r.fl = fl;
      r.ir = ir; r.ov = ov; r.od = od; r.oc = oc;
      tbl.push_back(r);
   endtask

   task automatic run_tbl(input string nm);
      foreach (tbl[k]) begin
         in_valid  = tbl[k].iv;
         in_data   = tbl[k].di;
         out_ready = tbl[k].ordy;
         flush     = tbl[k].fl;
         @(negedge clk);
         chk($sformatf("%s%0d_ir", nm, k), in_ready, tbl[k].ir);
         chk($sformatf("%s%0d_ov", nm, k), out_valid, tbl[k].ov);
         if (tbl[k].ov)
            chk($sformatf("%s%0d_od", nm, k), out_data, tbl[k].od);
`ifdef NPU_PIPE_OCC_EN
         chk($sformatf("%s%0d_oc", nm, k), occ, tbl[k].oc);
`endif
         @(posedge clk);
         #1;
      end
      tbl.delete();
      in_valid  = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      chk("rst_ov", out_valid, 1'b0);
      chk("rst_od", out_data, RD);
      chk("rst_ir", in_ready, 1'b1);
`ifdef NPU_PIPE_OCC_EN
      chk("rst_oc", occ, 0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: streaming, latency DEPTH, one beat per cycle
      for (int c = 0; c < 20; c++)
         row(c < 16, 8'(c + 1), 1'b1, 1'b0, 1'b1,
             (c >= 3 && c <= 18), 8'(c - 2),
             (c < 3) ? c : ((c <= 16) ? 3 : 19 - c));
      run_tbl("s");

      // 2: stall packs three beats, then drains in order
      row(1, 8'hA1, 0, 0, 1, 0, 8'h00, 0);
      row(1, 8'hA2, 0, 0, 1, 0, 8'h00, 1);
      row(1, 8'hA3, 0, 0, 1, 0, 8'h00, 2);
      row(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3);
      row(1, 8'hA4, 0, 0, 0, 1, 8'hA1, 3);
      row(1, 8'hA4, 1, 0, 1, 1, 8'hA1, 3);
      row(1, 8'hA5, 1, 0, 1, 1, 8'hA2, 3);
      row(0, 8'h00, 1, 0, 1, 1, 8'hA3, 3);
      row(0, 8'h00, 1, 0, 1, 1, 8'hA4, 2);
      row(0, 8'h00, 1, 0, 1, 1, 8'hA5, 1);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      run_tbl("k");

      // 3: full pipe, emit and accept in the same cycle
      row(1, 8'h31, 0, 0, 1, 0, 8'h00, 0);
      row(1, 8'h32, 0, 0, 1, 0, 8'h00, 1);
      row(1, 8'h33, 0, 0, 1, 0, 8'h00, 2);
      row(1, 8'hB7, 1, 0, 1, 1, 8'h31, 3);
      row(0, 8'h00, 0, 0, 0, 1, 8'h32, 3);
      row(0, 8'h00, 1, 0, 1, 1, 8'h32, 3);
      row(0, 8'h00, 1, 0, 1, 1, 8'h33, 2);
      row(0, 8'h00, 1, 0, 1, 1, 8'hB7, 1);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      run_tbl("f");

      // 4: flush with two beats in flight and a beat offered
      row(1, 8'hD1, 0, 0, 1, 0, 8'h00, 0);
      row(1, 8'hD2, 0, 0, 1, 0, 8'h00, 1);
      row(1, 8'hCC, 0, 1, 0, 0, 8'h00, 2);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      run_tbl("x");

      // 5: asynchronous reset between edges while full
      row(1, 8'hE1, 0, 0, 1, 0, 8'h00, 0);
      row(1, 8'hE2, 0, 0, 1, 0, 8'h00, 1);
      row(1, 8'hE3, 0, 0, 1, 0, 8'h00, 2);
      row(0, 8'h00, 0, 0, 0, 1, 8'hE1, 3);
      run_tbl("r");
      #2;
      reset = 1'b1;
      #1;
      chk("ar_ov", out_valid, 1'b0);
      chk("ar_od", out_data, RD);
      chk("ar_ir", in_ready, 1'b1);
`ifdef NPU_PIPE_OCC_EN
      chk("ar_oc", occ, 0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      row(1, 8'hF1, 1, 0, 1, 0, 8'h00, 0);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
      row(0, 8'h00, 1, 0, 1, 1, 8'hF1, 1);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      row(0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
      run_tbl("p");

      // 6: random valid/ready against an in-order scoreboard
      for (int c = 0; c < 2000; c++) begin
         beat_t b;
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("rnd_ir", in_ready,
             out_ready | (sb.size() < DP));
`ifdef NPU_PIPE_OCC_EN
         chk("rnd_oc", occ, sb.size());
`endif
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_dup", 1'b1, 1'b0);
            end else begin
               b = sb.pop_front();
               chk("rnd_od", out_data, b.d);
               chk("rnd_lat", (c - b.t) >= DP, 1'b1);
            end
         end
         if (in_valid && in_ready) begin
            b.d = in_data;
            b.t = c;
            sb.push_back(b);
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("drn_dup", 1'b1, 1'b0);
            end else begin
               beat_t b;
               b = sb.pop_front();
               chk("drn_od", out_data, b.d);
            end
         end
         @(posedge clk);
         #1;
      end
      chk("drn_left", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
